// File: rtl/doorway_pkg.sv
`default_nettype none
// ============================================================================
// Module      : doorway_pkg
// Description : Shared types and constants for the doorway direction detector:
//               crossing FSM state encoding, synchronizer depth and a helper
//               that classifies a state as part of an active crossing.
// Revision    : 1.0 - initial release
// ============================================================================
package doorway_pkg;

    // Flops in each beam's metastability synchronizer
    localparam int c_sync_stages = 2;

    // Crossing FSM states. E* track an entry (outer beam first), L* track an
    // exit (inner beam first), WAIT_CLEAR absorbs ambiguous or aborted activity.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_E1         = 3'd1,
        ST_E2         = 3'd2,
        ST_E3         = 3'd3,
        ST_L1         = 3'd4,
        ST_L2         = 3'd5,
        ST_L3         = 3'd6,
        ST_WAIT_CLEAR = 3'd7
    } state_t;

    // True while a directional crossing is in progress
    function automatic logic is_crossing(input state_t s);
        return (s != ST_IDLE) && (s != ST_WAIT_CLEAR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/beam_debounce.sv
`default_nettype none
// ============================================================================
// Module      : beam_debounce
// Description : Brings one asynchronous beam input into the clk domain through
//               a flop synchronizer, then only accepts a new level after
//               DEBOUNCE_CYCLES consecutive equal synchronized samples.
//               Input edge to level change latency is 2 + DEBOUNCE_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module beam_debounce
    import doorway_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic beam,
    output logic level
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit
    localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [c_sync_stages-1:0] r_sync;
    logic                     w_sample;
    logic [c_cnt_w-1:0]       r_cnt;
    logic                     r_level;

    assign w_sample = r_sync[c_sync_stages-1];
    assign level    = r_level;

    // Metastability synchronizer: shift the raw beam through c_sync_stages flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[c_sync_stages-2:0], beam};
        end
    end

    // Count consecutive samples that disagree with the accepted level; the
    // DEBOUNCE_CYCLES-th disagreeing sample in a row is taken as the new level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (w_sample == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
            r_level <= w_sample;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

endmodule
`default_nettype wire

// File: rtl/doorway_direction_detector.sv
`default_nettype none
// ============================================================================
// Module      : doorway_direction_detector
// Description : Decodes the order in which an outer (corridor side) and an
//               inner (room side) infrared beam are broken into one-cycle
//               entering / leaving pulses and maintains a saturating room
//               occupancy count.
//               Optional macro DOORWAY_TIMEOUT_EN: aborts a crossing that
//               stays incomplete for TIMEOUT_CYCLES and pulses fault.
// Revision    : 1.0 - initial release
// ============================================================================
module doorway_direction_detector
    import doorway_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_W         = 8,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               beam_outer,
    input  logic               beam_inner,
    output logic               entering,
    output logic               leaving,
    output logic [COUNT_W-1:0] occupancy,
    output logic               occupied,
    output logic               fault
);

    localparam logic [COUNT_W-1:0] c_occ_max  = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] c_occ_one  = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] c_occ_zero = '0;

    logic               w_o;
    logic               w_i;
    logic               w_timeout;
    state_t             r_state;
    logic               r_entering;
    logic               r_leaving;
    logic [COUNT_W-1:0] r_occ;
    logic               r_occupied;

    assign entering  = r_entering;
    assign leaving   = r_leaving;
    assign occupancy = r_occ;
    assign occupied  = r_occupied;

    beam_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_outer (
        .clk   (clk),
        .rst_n (rst_n),
        .beam  (beam_outer),
        .level (w_o)
    );

    beam_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_inner (
        .clk   (clk),
        .rst_n (rst_n),
        .beam  (beam_inner),
        .level (w_i)
    );

`ifdef DOORWAY_TIMEOUT_EN
    localparam int c_tmo_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_one  = c_tmo_w'(1);

    logic [c_tmo_w-1:0] r_timer;
    logic               r_fault;

    // Abort on the cycle the crossing reaches an age of TIMEOUT_CYCLES
    assign w_timeout = is_crossing(r_state) && (r_timer == c_tmo_last);
    assign fault     = r_fault;

    // Age of the crossing in progress; spans all E*/L* states of one crossing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (!is_crossing(r_state) || w_timeout) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + c_tmo_one;
        end
    end

    // Registered one-cycle fault pulse aligned with the abort to WAIT_CLEAR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_timeout;
        end
    end
`else
    assign w_timeout = 1'b0;

    // No timeout hardware: fault stays low unless TIMEOUT_CYCLES is nonsensical
    generate
        if (TIMEOUT_CYCLES >= 1) begin : g_fault_idle
            assign fault = 1'b0;
        end else begin : g_fault_bad_cfg
            assign fault = 1'b1;
        end
    endgenerate
`endif

    // Crossing decoder: state, registered direction pulses and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_entering <= 1'b0;
            r_leaving  <= 1'b0;
            r_occ      <= '0;
            r_occupied <= 1'b0;
        end else begin
            r_entering <= 1'b0;
            r_leaving  <= 1'b0;
            if (w_timeout) begin
                // Stale crossing: count is left alone, wait for a clear doorway
                r_state <= ST_WAIT_CLEAR;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        case ({w_o, w_i})
                            2'b10:   r_state <= ST_E1;
                            2'b01:   r_state <= ST_L1;
                            2'b11:   r_state <= ST_WAIT_CLEAR;
                            default: r_state <= ST_IDLE;
                        endcase
                    end
                    ST_E1: begin
                        case ({w_o, w_i})
                            2'b11:   r_state <= ST_E2;
                            2'b00:   r_state <= ST_IDLE;
                            2'b01:   r_state <= ST_E3;
                            default: r_state <= ST_E1;
                        endcase
                    end
                    ST_E2: begin
                        case ({w_o, w_i})
                            2'b01:   r_state <= ST_E3;
                            2'b10:   r_state <= ST_E1;
                            2'b00:   r_state <= ST_IDLE;
                            default: r_state <= ST_E2;
                        endcase
                    end
                    ST_E3: begin
                        case ({w_o, w_i})
                            2'b00: begin
                                // Person stepped fully into the room
                                r_state    <= ST_IDLE;
                                r_entering <= 1'b1;
                                r_occupied <= 1'b1;
                                if (r_occ != c_occ_max) begin
                                    r_occ <= r_occ + c_occ_one;
                                end
                            end
                            2'b11:   r_state <= ST_E2;
                            2'b10:   r_state <= ST_E1;
                            default: r_state <= ST_E3;
                        endcase
                    end
                    ST_L1: begin
                        case ({w_o, w_i})
                            2'b11:   r_state <= ST_L2;
                            2'b00:   r_state <= ST_IDLE;
                            2'b10:   r_state <= ST_L3;
                            default: r_state <= ST_L1;
                        endcase
                    end
                    ST_L2: begin
                        case ({w_o, w_i})
                            2'b10:   r_state <= ST_L3;
                            2'b01:   r_state <= ST_L1;
                            2'b00:   r_state <= ST_IDLE;
                            default: r_state <= ST_L2;
                        endcase
                    end
                    ST_L3: begin
                        case ({w_o, w_i})
                            2'b00: begin
                                // Person stepped fully into the corridor
                                r_state   <= ST_IDLE;
                                r_leaving <= 1'b1;
                                if (r_occ != c_occ_zero) begin
                                    r_occ <= r_occ - c_occ_one;
                                end
                                r_occupied <= (r_occ > c_occ_one);
                            end
                            2'b11:   r_state <= ST_L2;
                            2'b01:   r_state <= ST_L1;
                            default: r_state <= ST_L3;
                        endcase
                    end
                    ST_WAIT_CLEAR: begin
                        if (!w_o && !w_i) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_doorway_direction_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_doorway_direction_detector
// Description : Scoreboard bench for doorway_direction_detector. Each crossing
//               pushes the expected pulse (kind, cycle, occupancy) when the
//               last beam is released; a negedge monitor pops and compares
//               every pulse the design produces.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_doorway_direction_detector;
    import doorway_pkg::*;

    localparam int c_deb   = 4;
    localparam int c_cw    = 4;
    localparam int c_tmo   = 32;
    localparam int c_max   = 15;
    localparam int c_lat   = 2 + c_deb + 1;

    localparam logic [2:0] c_ev_enter = 3'b100;
    localparam logic [2:0] c_ev_leave = 3'b010;
    localparam logic [2:0] c_ev_fault = 3'b001;

    typedef struct {
        logic [2:0] kind;
        int         occ;
        int         cyc;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            beam_outer;
    logic            beam_inner;
    logic            entering;
    logic            leaving;
    logic [c_cw-1:0] occupancy;
    logic            occupied;
    logic            fault;

    ev_t q[$];
    int  cyc    = 0;
    int  m_occ  = 0;
    int  n_cmp  = 0;
    int  n_err  = 0;

    doorway_direction_detector #(
        .DEBOUNCE_CYCLES (c_deb),
        .COUNT_W         (c_cw),
        .TIMEOUT_CYCLES  (c_tmo)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .beam_outer (beam_outer),
        .beam_inner (beam_inner),
        .entering   (entering),
        .leaving    (leaving),
        .occupancy  (occupancy),
        .occupied   (occupied),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [2:0] kind, input int occ, input int at);
        ev_t e;
        e.kind = kind;
        e.occ  = occ;
        e.cyc  = at;
        q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk("drain", q.size(), 0);
        q.delete();
    endtask

    task automatic do_entry();
        beam_outer = 1'b1; tick(10);
        beam_inner = 1'b1; tick(10);
        beam_outer = 1'b0; tick(10);
        beam_inner = 1'b0;
        m_occ = (m_occ == c_max) ? c_max : m_occ + 1;
        push(c_ev_enter, m_occ, cyc + c_lat);
        wait_drain(20);
    endtask

    task automatic do_exit();
        beam_inner = 1'b1; tick(10);
        beam_outer = 1'b1; tick(10);
        beam_inner = 1'b0; tick(10);
        beam_outer = 1'b0;
        m_occ = (m_occ == 0) ? 0 : m_occ - 1;
        push(c_ev_leave, m_occ, cyc + c_lat);
        wait_drain(20);
    endtask

    // Every pulse must match the oldest pending expectation
    always @(negedge clk) begin
        ev_t e;
        if (rst_n === 1'b1 && (entering || leaving || fault)) begin
            if (q.size() == 0) begin
                chk("spurious_pulse", {entering, leaving, fault}, 3'b000);
            end else begin
                e = q.pop_front();
                chk("pulse_kind", {entering, leaving, fault}, e.kind);
                chk("pulse_cycle", cyc, e.cyc);
                chk("occupancy", occupancy, e.occ);
                chk("occupied", occupied, (e.occ != 0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time budget exceeded at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        beam_outer = 1'b0;
        beam_inner = 1'b0;
        tick(3);
        chk("rst_entering", entering, 0);
        chk("rst_leaving", leaving, 0);
        chk("rst_fault", fault, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_occupied", occupied, 0);
        rst_n = 1'b1;
        tick(5);

        // Entry, exit, then an exit from an empty room
        do_entry();
        chk("entry_occ", occupancy, m_occ);
        do_exit();
        chk("exit_occ", occupancy, m_occ);
        do_exit();
        chk("empty_exit_occ", occupancy, 0);

        // Back-out: outer beam only, then released
        beam_outer = 1'b1; tick(10);
        chk("backout_e1", dut.r_state, ST_E1);
        beam_outer = 1'b0; tick(10);
        chk("backout_idle", dut.r_state, ST_IDLE);
        chk("backout_occ", occupancy, m_occ);

        // Glitch shorter than the debounce window
        beam_outer = 1'b1; tick(3);
        beam_outer = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("glitch_state", dut.r_state, ST_IDLE);
        end
        tick(1);

        // Outer beam held far beyond the timeout
`ifdef DOORWAY_TIMEOUT_EN
        beam_outer = 1'b1;
        push(c_ev_fault, m_occ, cyc + c_lat + c_tmo);
        tick(60);
        chk("timeout_wait", dut.r_state, ST_WAIT_CLEAR);
        beam_outer = 1'b0;
        wait_drain(5);
        tick(10);
        chk("timeout_idle", dut.r_state, ST_IDLE);
`else
        beam_outer = 1'b1;
        tick(60);
        chk("hold_e1", dut.r_state, ST_E1);
        beam_outer = 1'b0;
        tick(10);
        chk("hold_idle", dut.r_state, ST_IDLE);
`endif
        do_entry();
        chk("post_hold_occ", occupancy, 1);

        // Saturation at all-ones
        for (int k = 0; k < 16; k++) begin
            do_entry();
        end
        chk("sat_occ", occupancy, c_max);
        chk("sat_occupied", occupied, 1);

        // Asynchronous reset in the middle of a crossing
        rst_n = 1'b0; tick(2);
        rst_n = 1'b1; m_occ = 0; tick(3);
        for (int k = 0; k < 3; k++) begin
            do_entry();
        end
        chk("pre_rst_occ", occupancy, 3);
        beam_outer = 1'b1; tick(10);
        beam_inner = 1'b1; tick(10);
        chk("pre_rst_e2", dut.r_state, ST_E2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_entering", entering, 0);
        chk("arst_leaving", leaving, 0);
        chk("arst_fault", fault, 0);
        chk("arst_occupancy", occupancy, 0);
        chk("arst_occupied", occupied, 0);
        chk("arst_state", dut.r_state, ST_IDLE);
        beam_outer = 1'b0;
        beam_inner = 1'b0;
        tick(3);
        rst_n = 1'b1;
        m_occ = 0;
        tick(3);
        do_entry();
        chk("post_rst_occ", occupancy, 1);
        chk("post_rst_occupied", occupied, 1);

        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
